// File: rtl/seven_segment_bcd_driver.sv
// Binary-to-BCD display driver: double-dabble conversion into six active-low
// 7-segment codes, with optional leading-zero blanking and overflow dashes.
module seven_segment_bcd_driver #(
    parameter int WIDTH         = 20,
    parameter int BLANK_LEADING = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [6:0]       disp0,
    output logic [6:0]       disp1,
    output logic [6:0]       disp2,
    output logic [6:0]       disp3,
    output logic [6:0]       disp4,
    output logic [6:0]       disp5
);

    localparam int         CNT_W    = 5;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [19:0] MAX_SHOWN = 20'd999999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        ENCODE  = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   shreg_r;
    logic [23:0]        bcd_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_pending_r;
    logic               busy_r;
    logic               done_r;
    logic               overflow_r;
    logic [5:0][6:0]    disp_r;

    logic [19:0]        value_ext_s;
    logic [23:0]        bcd_adj_s;
    logic [5:0][6:0]    disp_next_s;

    // Adds 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [23:0] bcd_adjust(input logic [23:0] b);
        logic [23:0] r;
        logic [3:0]  n;
        r = b;
        for (int i = 0; i < 6; i++) begin
            n = b[4*i +: 4];
            if (n >= 4'd5) begin
                r[4*i +: 4] = n + 4'd3;
            end else begin
                r[4*i +: 4] = n;
            end
        end
        return r;
    endfunction

    // Active-low segment code, bit0=a .. bit6=g.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign value_ext_s = 20'(value_in);
    assign bcd_adj_s   = bcd_adjust(bcd_r);

    // Next display codes: dashes on overflow, else digits scanned from the top with blanking.
    always_comb begin
        logic       lead_v;
        logic [3:0] digit_v;
        disp_next_s = {6{SEG_BLANK}};
        lead_v      = 1'b1;
        digit_v     = 4'd0;
        for (int i = 5; i >= 0; i--) begin
            digit_v = bcd_r[4*i +: 4];
            if (ovf_pending_r) begin
                disp_next_s[i] = SEG_DASH;
            end else if ((BLANK_LEADING != 0) && lead_v && (digit_v == 4'd0) && (i != 0)) begin
                disp_next_s[i] = SEG_BLANK;
            end else begin
                disp_next_s[i] = seg_code(digit_v);
                lead_v         = 1'b0;
            end
        end
    end

    // Control FSM with conversion datapath and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            shreg_r       <= '0;
            bcd_r         <= 24'd0;
            cnt_r         <= 5'd0;
            ovf_pending_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            overflow_r    <= 1'b0;
            disp_r        <= {6{SEG_BLANK}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (load) begin
                        shreg_r       <= value_in;
                        bcd_r         <= 24'd0;
                        cnt_r         <= 5'd0;
                        ovf_pending_r <= (value_ext_s > MAX_SHOWN);
                        busy_r        <= 1'b1;
                        state_r       <= CONVERT;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CONVERT: begin
                    // Bits shifted out of the top BCD nibble only matter for overflowed values.
                    bcd_r   <= {bcd_adj_s[22:0], shreg_r[WIDTH-1]};
                    shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
                    cnt_r   <= cnt_r + 5'd1;
                    done_r  <= 1'b0;
                    if (cnt_r == 5'(WIDTH - 1)) begin
                        state_r <= ENCODE;
                    end else begin
                        state_r <= CONVERT;
                    end
                end
                ENCODE: begin
                    disp_r     <= disp_next_s;
                    overflow_r <= ovf_pending_r;
                    done_r     <= 1'b1;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign disp0    = disp_r[0];
    assign disp1    = disp_r[1];
    assign disp2    = disp_r[2];
    assign disp3    = disp_r[3];
    assign disp4    = disp_r[4];
    assign disp5    = disp_r[5];

endmodule

// File: doc/seven_segment_bcd_driver.md
Name: seven_segment_bcd_driver

Overview:
- Upstream stage for the board's six 7-segment displays.
- Accepts a binary value on a load strobe and converts it to six BCD digits with an iterative shift-add-3 (double-dabble) engine.
- Encodes the digits to active-low segment codes with leading-zero blanking.
- Holds the registered codes on disp0..disp5, which go straight to the display pins.

Parameters:
- WIDTH, 20, binary input width; legal range 4..20; conversion takes WIDTH shift cycles.
- BLANK_LEADING, 1, 1 = blank leading-zero digits; 0 = show all six digits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- value_in  input  WIDTH  unsigned binary value to display
- load  input  1  start conversion; sampled only in IDLE
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the displays update
- overflow  output  1  latched: last accepted value was > 999999
- disp0  output  7  digit 0 (least significant, rightmost), active-low, bit0=a .. bit6=g
- disp1..disp5  output  7 each  digits 1..5, same encoding; disp5 is most significant

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, overflow=0.
  - disp0..disp5 = 7'b1111111 (blank).
  - Shift/BCD registers cleared.
- States: IDLE -> CONVERT -> ENCODE -> IDLE.
- IDLE:
  - On an edge with load=1: capture value_in into the shift register, clear the 24-bit BCD register, set cnt=0, go to CONVERT.
  - At the same edge, compute ovf_pending = (value_in > 999999).
  - busy=1 from this edge onward.
- CONVERT, one shift per edge:
  - Each BCD nibble >= 5 gets +3 (all nibbles in parallel).
  - Then {bcd, shreg} shift left by 1. cnt increments.
  - After WIDTH shifts, go to ENCODE.
- ENCODE, single edge:
  - disp registers, overflow and done update together.
  - busy=0 and state=IDLE after this edge.
- Latency: display changes exactly WIDTH+1 edges after the load edge (21 for the default).
- done is high for exactly the one cycle following the ENCODE edge. busy and done are never both high.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, dash=0111111
- Blanking (BLANK_LEADING=1):
  - disp5..disp1 blank while the digit and all more-significant digits are 0.
  - disp0 is always shown, so value 0 shows "0".
- Overflow (value > 999999, possible only when WIDTH=20):
  - Conversion runs with normal timing.
  - At ENCODE, all six displays show dash and overflow=1.
  - overflow is cleared at the ENCODE of the next in-range value.
- load while busy is ignored; there is no queueing.
- load asserted in the done cycle is accepted (state is IDLE).
- value_in is sampled only at the load edge; later changes do not affect the result.
- rst_n asserted mid-conversion aborts the conversion, blanks the displays and produces no done pulse.
- Displays hold their last value indefinitely between conversions.
- Nibble +3 correction uses 4-bit arithmetic. No nibble exceeds 9 after a shift for in-range inputs.

Test Plan:
- Reset with rst_n low mid-cycle -> disp0..5=1111111 immediately (asynchronous); busy=0, done=0, overflow=0.
- load with value_in=420 -> busy high for 21 cycles, then done pulses once. disp0=1000000 ("0"), disp1=0100100 ("2"), disp2=0011001 ("4"), disp3..5=1111111.
- load with value_in=0 -> disp0=1000000, disp1..5 blank. load with value_in=999999 -> all six displays 0010000 ("9"), overflow=0.
- load with value_in=1000000 -> all six displays 0111111 (dash), overflow=1. Next load with value_in=7 -> disp0=1111000, others blank, overflow=0.
- load with 123456, then load with 654321 pulsed at cycle 5 of busy -> second load ignored; display shows 123456 after 21 cycles. load with 654321 again in the done cycle -> accepted; 654321 displayed 21 cycles later.
- load with 42, then rst_n low at cycle 10 of busy -> displays blank, no done pulse. After release, load with 5 -> disp0=0010010.
